// File: rtl/jhash_mix_pkg.sv
// Shared definitions for the lookup3 hashword engine: FSM states, step
// modes, seed constant and the per-step rotation / operand-routing tables.
package jhash_mix_pkg;

    localparam logic [31:0] JH_INIT_CONST = 32'hdeadbeef;
    localparam int          JH_LEN_W      = 16;

    localparam logic [2:0]  MIX_LAST      = 3'd5;
    localparam logic [2:0]  FINAL_LAST    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_MIX   = 3'd2,
        ST_FINAL = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    typedef enum logic {
        MODE_MIX   = 1'b0,
        MODE_FINAL = 1'b1
    } step_mode_t;

    // Operand select encodes which register plays x: 0=a, 1=b, 2=c.
    // z is always the register that precedes x in the a<-c, b<-a, c<-b ring.
    typedef logic [1:0] sel_t;

    function automatic logic [4:0] mix_rot(input logic [2:0] step);
        case (step)
            3'd0:    return 5'd4;
            3'd1:    return 5'd6;
            3'd2:    return 5'd8;
            3'd3:    return 5'd16;
            3'd4:    return 5'd19;
            default: return 5'd4;
        endcase
    endfunction

    function automatic logic [4:0] final_rot(input logic [2:0] step);
        case (step)
            3'd0:    return 5'd14;
            3'd1:    return 5'd11;
            3'd2:    return 5'd25;
            3'd3:    return 5'd16;
            3'd4:    return 5'd4;
            3'd5:    return 5'd14;
            default: return 5'd24;
        endcase
    endfunction

    function automatic sel_t mix_sel(input logic [2:0] step);
        case (step)
            3'd0, 3'd3: return 2'd0;
            3'd1, 3'd4: return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

    function automatic sel_t final_sel(input logic [2:0] step);
        case (step)
            3'd1, 3'd4: return 2'd0;
            3'd2, 3'd5: return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/jhash_mix_step.sv
// One lookup3 mix or final line, purely combinational.
//   mix:   x' = (x - z) ^ rotl(z, r);  z' = z + y
//   final: x' = (x ^ z) - rotl(z, r);  z' = z
module jhash_mix_step
    import jhash_mix_pkg::*;
(
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    input  logic [31:0] i_z,
    input  logic [4:0]  i_rot,
    input  step_mode_t  i_mode,
    output logic [31:0] o_x,
    output logic [31:0] o_z
);

    logic [63:0] w_dbl;
    logic [31:0] w_rotz;

    // Left-rotate z by doubling it and shifting, which stays correct for any r.
    always_comb begin
        w_dbl  = {i_z, i_z} << i_rot;
        w_rotz = w_dbl[63:32];
        if (i_mode == MODE_MIX) begin
            o_x = (i_x - i_z) ^ w_rotz;
            o_z = i_z + i_y;
        end else begin
            o_x = (i_x ^ i_z) - w_rotz;
            o_z = i_z;
        end
    end

endmodule

// File: rtl/jhash_mix.sv
// lookup3 hashword() engine fed by 3-word beats, one mix/final line per clock.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no hash in flight; start seeds a/b/c
//   ST_WAIT  | ready for the next beat; only state that acks
//   ST_MIX   | six mix lines after a non-tail beat, then back to WAIT
//   ST_FINAL | seven final lines after a tail beat with 1..3 words
//   ST_OUT   | publish c on hash_out with a one-cycle hash_valid
module jhash_mix
    import jhash_mix_pkg::*;
#(
    parameter logic [31:0] INIT_CONST = JH_INIT_CONST,
    parameter int          LEN_W      = JH_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [31:0]      cfg_initval,
    input  logic [31:0]      stream_data0,
    input  logic [31:0]      stream_data1,
    input  logic [31:0]      stream_data2,
    input  logic             stream_valid,
    input  logic             stream_done,
    input  logic [1:0]       stream_left,
    output logic             stream_ack,
    output logic             busy,
    output logic             hash_valid,
    output logic [31:0]      hash_out
);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_step;
    logic [31:0] r_a, r_b, r_c;
    logic [31:0] r_hash_out;
    logic        r_hash_valid;

    sel_t        w_sel;
    logic [4:0]  w_rot;
    step_mode_t  w_mode;
    logic [31:0] w_x, w_y, w_z;
    logic [31:0] w_x_new, w_z_new;
    logic [31:0] w_seed;

    assign w_seed     = INIT_CONST + (32'(cfg_len) << 2) + cfg_initval;
    assign busy       = (r_state != ST_IDLE);
    assign hash_valid = r_hash_valid;
    assign hash_out   = r_hash_out;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode and the combinational beat acknowledge.
    always_comb begin
        w_next_state = r_state;
        stream_ack   = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_WAIT;
            ST_WAIT: begin
                stream_ack = stream_valid;
                if (stream_valid) begin
                    if (!stream_done)             w_next_state = ST_MIX;
                    else if (stream_left == 2'd0) w_next_state = ST_OUT;
                    else                          w_next_state = ST_FINAL;
                end
            end
            ST_MIX:   if (r_step == MIX_LAST)   w_next_state = ST_WAIT;
            ST_FINAL: if (r_step == FINAL_LAST) w_next_state = ST_OUT;
            ST_OUT:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Route a/b/c onto the step unit's x/y/z for the current line.
    always_comb begin
        w_mode = (r_state == ST_FINAL) ? MODE_FINAL : MODE_MIX;
        w_sel  = (r_state == ST_FINAL) ? final_sel(r_step) : mix_sel(r_step);
        w_rot  = (r_state == ST_FINAL) ? final_rot(r_step) : mix_rot(r_step);
        case (w_sel)
            2'd0:    begin w_x = r_a; w_y = r_b; w_z = r_c; end
            2'd1:    begin w_x = r_b; w_y = r_c; w_z = r_a; end
            default: begin w_x = r_c; w_y = r_a; w_z = r_b; end
        endcase
    end

    jhash_mix_step u_step (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_z    (w_z),
        .i_rot  (w_rot),
        .i_mode (w_mode),
        .o_x    (w_x_new),
        .o_z    (w_z_new)
    );

    // Hash datapath: seeding, beat accumulation, step write-back, result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_step       <= '0;
            r_hash_out   <= '0;
            r_hash_valid <= 1'b0;
        end else begin
            r_hash_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a <= w_seed;
                        r_b <= w_seed;
                        r_c <= w_seed;
                    end
                end
                ST_WAIT: begin
                    if (stream_valid) begin
                        r_step <= '0;
                        if (!stream_done) begin
                            r_a <= r_a + stream_data0;
                            r_b <= r_b + stream_data1;
                            r_c <= r_c + stream_data2;
                        end else begin
                            if (stream_left >= 2'd1) r_a <= r_a + stream_data0;
                            if (stream_left >= 2'd2) r_b <= r_b + stream_data1;
                            if (stream_left == 2'd3) r_c <= r_c + stream_data2;
                        end
                    end
                end
                ST_MIX, ST_FINAL: begin
                    r_step <= r_step + 3'd1;
                    // In final mode w_z_new equals z, so writing it back is harmless.
                    case (w_sel)
                        2'd0:    begin r_a <= w_x_new; r_c <= w_z_new; end
                        2'd1:    begin r_b <= w_x_new; r_a <= w_z_new; end
                        default: begin r_c <= w_x_new; r_b <= w_z_new; end
                    endcase
                end
                ST_OUT: begin
                    r_hash_out   <= r_c;
                    r_hash_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
